bus_arbiter2: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the shared 32-bit 2:1 word mux in the pipeline datapath. It grants the mux to source A or source B through a req/gnt handshake and bounds each tenure to MAX_HOLD transfers when the other side is waiting. It registers the selected word onto a single output port with a valid flag. It sits between the two datapath producers (e.g. ALU result path and memory load path) and the shared write-back/forwarding bus.

---
 rtl/bus_arbiter2_if.sv | 23 ++
 rtl/bus_arbiter2.sv | 75 +++++++
 tb/tb_bus_arbiter2.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter2_if.sv
// bus_arbiter2_if: request/grant and output bus shared by two producers and the arbiter.
//   master: req_a/req_b, data_a/data_b out; gnt_a/gnt_b, sel, out_data, out_valid, out_src in
//   slave : the arbiter side, directions reversed
interface bus_arbiter2_if #(parameter int WIDTH = 32);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_src;
    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, out_data, out_valid, out_src
    );
    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, out_data, out_valid, out_src
    );
endinterface

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-requester round-robin arbiter for the shared 2:1 word mux, with tenure bound.
//   clk, rst (async, active-high); bus (slave modport): req/data in, gnt/sel/out_* out.
//   ARB_STATS_EN adds cnt_a/cnt_b saturating 16-bit transfer counters.
module bus_arbiter2 #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    bus_arbiter2_if.slave       bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]         cnt_a,
    output logic [15:0]         cnt_b
`endif
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    state_t           state, next_state;
    logic [3:0]       hold_cnt, next_hold;
    logic             last_a;
    logic             xfer_a, xfer_b, xfer, at_max;
    logic [WIDTH-1:0] word;
    assign xfer_a    = (state == OWN_A) && bus.req_a;
    assign xfer_b    = (state == OWN_B) && bus.req_b;
    assign xfer      = xfer_a || xfer_b;
    assign at_max    = hold_cnt == 4'(MAX_HOLD - 1);
    assign word      = xfer_a ? bus.data_a : bus.data_b;
    assign bus.gnt_a = state == OWN_A;
    assign bus.gnt_b = state == OWN_B;
    assign bus.sel   = state == OWN_A;
    always_comb begin
        next_state = state;
        // Only a transfer below the bound keeps counting; renewal, handover and idle all restart at 0.
        next_hold  = (xfer && !at_max) ? hold_cnt + 4'd1 : 4'd0;
        case (state)
            IDLE:    next_state = (bus.req_a && bus.req_b) ? (last_a ? OWN_B : OWN_A) :
                                  bus.req_a ? OWN_A : bus.req_b ? OWN_B : IDLE;
            OWN_A:   next_state = !bus.req_a ? (bus.req_b ? OWN_B : IDLE) :
                                  (at_max && bus.req_b) ? OWN_B : OWN_A;
            OWN_B:   next_state = !bus.req_b ? (bus.req_a ? OWN_A : IDLE) :
                                  (at_max && bus.req_a) ? OWN_A : OWN_B;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= 4'd0;
            last_a        <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_src   <= 1'b0;
        end else begin
            state         <= next_state;
            hold_cnt      <= next_hold;
            bus.out_valid <= xfer;
            if (xfer) begin
                last_a       <= xfer_a;
                bus.out_data <= word;
                bus.out_src  <= xfer_a;
            end
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= 16'd0;
            cnt_b <= 16'd0;
        end else begin
            cnt_a <= cnt_a + 16'(xfer_a && cnt_a != 16'hFFFF);
            cnt_b <= cnt_b + 16'(xfer_b && cnt_b != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2: scoreboard bench for bus_arbiter2 (MAX_HOLD=4); ARB_STATS_EN adds counter checks.
module tb_bus_arbiter2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [32:0] sb[$];
    bus_arbiter2_if #(.WIDTH(32)) bus ();
`ifdef ARB_STATS_EN
    logic [15:0] cnt_a, cnt_b;
`endif
    bus_arbiter2 #(.WIDTH(32), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .cnt_a(cnt_a),
        .cnt_b(cnt_b)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic void expect_words(input logic src, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) sb.push_back({src, d});
    endfunction
    always @(negedge clk) begin
        if (bus.out_valid) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                check("out_data", bus.out_data, e[31:0]);
                check("out_src", 32'(bus.out_src), 32'(e[32]));
            end
        end
    end
    initial begin
        int g, v;
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 32'h12345678;
        bus.data_b = 32'h87654321;
        tick();
        tick();
        check("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
        check("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_src", 32'(bus.out_src), 32'd0);
        rst = 1'b0;
        tick();
        check("first_tie_a", 32'(bus.gnt_a), 32'd1);
        check("first_tie_sel", 32'(bus.sel), 32'd1);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
        check("drop_idle", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
        // single source A
        bus.req_a  = 1'b1;
        bus.data_a = 32'hAAAAAAAA;
        expect_words(1'b1, 32'hAAAAAAAA, 3);
        g = 0;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.req_a = 1'b0;
            tick();
            g += int'(bus.gnt_a);
            v += int'(bus.out_valid);
        end
        check("single_gnt_cycles", 32'(g), 32'd4);
        check("single_valid_cycles", 32'(v), 32'd3);
        check("single_idle", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
        // contention: A served last, so B leads; 4/4 alternation with no gaps
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 32'hA5A5A5A5;
        bus.data_b = 32'h55555555;
        for (int k = 0; k < 2; k++) begin
            expect_words(1'b0, 32'h55555555, 4);
            expect_words(1'b1, 32'hA5A5A5A5, 4);
        end
        v = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 17) begin
                bus.req_a = 1'b0;
                bus.req_b = 1'b0;
            end
            tick();
            if (i == 0) check("tie_after_a_b", 32'(bus.gnt_b), 32'd1);
            if (i >= 1 && i <= 16) v += int'(bus.out_valid);
        end
        check("contention_valid", 32'(v), 32'd16);
        check("contention_idle", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
        // owner drop with B waiting: one bubble
        bus.req_a  = 1'b1;
        bus.data_a = 32'h11111111;
        bus.data_b = 32'hDDDDDDDD;
        expect_words(1'b1, 32'h11111111, 2);
        expect_words(1'b0, 32'hDDDDDDDD, 2);
        tick();
        bus.req_b = 1'b1;
        tick();
        tick();
        bus.req_a = 1'b0;
        tick();
        check("drop_bubble", 32'(bus.out_valid), 32'd0);
        check("drop_gnt_b", 32'(bus.gnt_b), 32'd1);
        tick();
        check("drop_b_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.req_b = 1'b0;
        tick();
        check("drop_b_idle", 32'(bus.gnt_b), 32'd0);
        // B served last -> A wins a tie
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        tick();
        check("tie_after_b_a", 32'(bus.gnt_a), 32'd1);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
        // A served last -> B wins a tie, then reset mid-tenure
        bus.req_a  = 1'b1;
        bus.data_a = 32'h0000A001;
        expect_words(1'b1, 32'h0000A001, 1);
        tick();
        tick();
        bus.req_a = 1'b0;
        tick();
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_b = 32'h0000B00B;
        tick();
        check("tie_after_a_b2", 32'(bus.gnt_b), 32'd1);
        expect_words(1'b0, 32'h0000B00B, 1);
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_gnt_b", 32'(bus.gnt_b), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", bus.out_data, 32'h0);
        check("mid_rst_hold", 32'(dut.hold_cnt), 32'd0);
`ifdef ARB_STATS_EN
        check("mid_rst_cnt_b", 32'(cnt_b), 32'd0);
`endif
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();
        check("after_rst_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        tick();
`ifdef ARB_STATS_EN
        force dut.cnt_b = 16'hFFFE;
        #1;
        release dut.cnt_b;
        bus.req_b  = 1'b1;
        bus.data_b = 32'h0000C0DE;
        expect_words(1'b0, 32'h0000C0DE, 2);
        tick();
        tick();
        tick();
        bus.req_b = 1'b0;
        tick();
        check("cnt_b_sat", 32'(cnt_b), 32'h0000FFFF);
        check("cnt_a_clear", 32'(cnt_a), 32'd0);
`endif
        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
